muldiv_unit: RTL and testbench

- Multi-cycle unsigned multiply/divide execution unit. Sits between the register file read ports and its write port.
- Consumes two 18-bit source operands read from the register file and a 4-bit destination index.
- Iterates one bit per cycle, then drives a single-cycle write into the register file (RegWrite/write_addr/write_data).
- The control unit holds issue while busy is high.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/muldiv_unit_if.sv | 31 +++
 rtl/muldiv_datapath.sv | 70 +++++++
 rtl/muldiv_unit.sv | 114 +++++++++++
 tb/tb_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multiply/divide execution unit.
//   WIDTH   : operand/result width, equal to the register file data width
//   AW      : destination register address width (16 registers)
//   CW      : iteration counter width
//   op_e    : operation encodings driven by the control unit
//   state_e : sequencing states of the multiply/divide FSM
package cpu_pkg;

  localparam int WIDTH = 18;
  localparam int AW    = 4;
  localparam int CW    = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIVU = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WB   = 2'b10
  } state_e;

  // Bit 1 of the encoding separates the divide family from the multiply family.
  function automatic logic isDivide(op_e op);
    return op[1];
  endfunction

  // MULH and REMU take the upper register of the datapath; MUL and DIVU the lower.
  function automatic logic selectsHigh(op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the control unit, register file and the
// multiply/divide unit.
//   master : issue side (start, op, src_a, src_b, dest, abort) and
//            observer of busy/writeback
//   slave  : the execution unit itself
interface muldiv_unit_if;
  import cpu_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [AW-1:0]    dest;
  logic             abort;
  logic             busy;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             done;

  modport master (
    output start, op, src_a, src_b, dest, abort,
    input  busy, wb_en, wb_addr, wb_data, done
  );

  modport slave (
    input  start, op, src_a, src_b, dest, abort,
    output busy, wb_en, wb_addr, wb_data, done
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Iterative datapath shared by multiply and divide.
//   i_init       : load operands (src_a into the low register, src_b as operand)
//   i_step       : perform one shift-add or restoring-divide iteration
//   i_isDiv      : select divide iteration instead of multiply
//   i_selHi      : result comes from the high register (MULH/REMU)
//   o_nextResult : selected result as it will be after the current step
// Multiply keeps {r_hi, r_lo} as the 2*WIDTH product, with the multiplier
// shifting out of r_lo. Divide keeps the partial remainder in r_hi and
// shifts quotient bits into r_lo as the dividend bits shift out.
module muldiv_datapath
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_init,
  input  logic             i_step,
  input  logic             i_isDiv,
  input  logic             i_selHi,
  input  logic [WIDTH-1:0] i_srcA,
  input  logic [WIDTH-1:0] i_srcB,
  output logic [WIDTH-1:0] o_nextResult
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic             w_fits;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_nextHi;
  logic [WIDTH-1:0] w_nextLo;

  // One iteration of either algorithm. When the trial subtract fits, the
  // difference is below the divisor, so a WIDTH-bit subtract is exact.
  // A zero divisor always fits, which yields an all-ones quotient and
  // leaves the dividend in the remainder without any special casing.
  always_comb begin
    w_sum     = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};
    w_shifted = {r_hi, r_lo[WIDTH-1]};
    w_fits    = (w_shifted >= {1'b0, r_opnd});
    w_diff    = w_shifted[WIDTH-1:0] - r_opnd;
    if (i_isDiv) begin
      w_nextHi = w_fits ? w_diff : w_shifted[WIDTH-1:0];
      w_nextLo = {r_lo[WIDTH-2:0], w_fits};
    end else begin
      w_nextHi = w_sum[WIDTH:1];
      w_nextLo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
    o_nextResult = i_selHi ? w_nextHi : w_nextLo;
  end

  // Operand and working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
    end else if (i_init) begin
      r_hi   <= '0;
      r_lo   <= i_srcA;
      r_opnd <= i_srcB;
    end else if (i_step) begin
      r_hi   <= w_nextHi;
      r_lo   <= w_nextLo;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit between register file reads and
// the register file write port.
//   clk, reset : clock and asynchronous active-high reset
//   io_bus     : issue inputs (start, op, src_a, src_b, dest, abort) and
//                outputs (busy, wb_en, wb_addr, wb_data, done)
// An accepted start spends WIDTH cycles in RUN, then one WB cycle where the
// registered write strobe and done pulse are high.
module muldiv_unit
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  io_bus
);

  state_e           r_state;
  state_e           w_nextState;
  logic [CW-1:0]    r_count;
  op_e              r_op;
  logic [AW-1:0]    r_dest;
  logic             r_wbEn;
  logic             r_done;
  logic [AW-1:0]    r_wbAddr;
  logic [WIDTH-1:0] r_wbData;
  logic             w_init;
  logic             w_step;
  logic             w_finish;
  logic [WIDTH-1:0] w_nextResult;

  muldiv_datapath u_datapath (
    .clk          (clk),
    .reset        (reset),
    .i_init       (w_init),
    .i_step       (w_step),
    .i_isDiv      (isDivide(r_op)),
    .i_selHi      (selectsHigh(r_op)),
    .i_srcA       (io_bus.src_a),
    .i_srcB       (io_bus.src_b),
    .o_nextResult (w_nextResult)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next state and datapath control. Abort takes priority over start in
  // IDLE and cancels in RUN; in WB the strobe is already out, so it only
  // matters that we return to IDLE, which happens anyway.
  always_comb begin
    w_nextState = r_state;
    w_init      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start && !io_bus.abort) begin
          w_init      = 1'b1;
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (io_bus.abort) begin
          w_nextState = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == CW'(WIDTH - 1)) begin
            w_finish    = 1'b1;
            w_nextState = S_WB;
          end
        end
      end
      S_WB:    w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Issue bookkeeping and registered writeback. The result is captured from
  // the datapath's post-step value on the final iteration so it is ready in
  // the WB cycle; address/data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_op     <= OP_MUL;
      r_dest   <= '0;
      r_wbEn   <= 1'b0;
      r_done   <= 1'b0;
      r_wbAddr <= '0;
      r_wbData <= '0;
    end else begin
      if (w_init) begin
        r_op    <= op_e'(io_bus.op);
        r_dest  <= io_bus.dest;
        r_count <= '0;
      end else if (w_step) begin
        r_count <= r_count + CW'(1);
      end
      r_wbEn <= w_finish;
      r_done <= w_finish;
      if (w_finish) begin
        r_wbAddr <= r_dest;
        r_wbData <= w_nextResult;
      end
    end
  end

  assign io_bus.busy    = (r_state != S_IDLE);
  assign io_bus.wb_en   = r_wbEn;
  assign io_bus.done    = r_done;
  assign io_bus.wb_addr = r_wbAddr;
  assign io_bus.wb_data = r_wbData;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. A cycle-level reference model
// (plain arithmetic results plus a countdown of remaining busy cycles)
// is compared against the DUT on every falling edge, and directed
// sequences add hand-computed literal expectations.
module tb_muldiv_unit;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: cycles left until the unit is idle again, the
  // pending result, and the last value written to the register file.
  int               mRemain   = 0;
  logic [WIDTH-1:0] mResult   = '0;
  logic [AW-1:0]    mDest     = '0;
  logic [WIDTH-1:0] mLastData = '0;
  logic [AW-1:0]    mLastAddr = '0;

  function automatic logic [WIDTH-1:0] refResult(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      2'b00:   return prod[WIDTH-1:0];
      2'b01:   return prod[2*WIDTH-1:WIDTH];
      2'b10:   return (b == '0) ? {WIDTH{1'b1}} : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // An accepted issue keeps the unit busy for WIDTH+1 cycles, the last of
  // which is the write. Abort while busy drops straight to idle; an abort
  // in the write cycle comes after the write has already been seen.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mRemain   <= 0;
      mLastData <= '0;
      mLastAddr <= '0;
    end else if (mRemain == 0) begin
      if (bus.start && !bus.abort) begin
        mRemain <= WIDTH + 1;
        mResult <= refResult(bus.op, bus.src_a, bus.src_b);
        mDest   <= bus.dest;
      end
    end else if (bus.abort) begin
      mRemain <= 0;
    end else begin
      mRemain <= mRemain - 1;
      if (mRemain == 2) begin
        mLastData <= mResult;
        mLastAddr <= mDest;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("busy",    bus.busy,    mRemain != 0);
    checkOutput("wb_en",   bus.wb_en,   mRemain == 1);
    checkOutput("done",    bus.done,    mRemain == 1);
    checkOutput("wb_addr", bus.wb_addr, mLastAddr);
    checkOutput("wb_data", bus.wb_data, mLastData);
  end

  // Issue one operation for a single cycle, then scramble the inputs to
  // show they are not re-sampled. Returns at the first falling edge after
  // the accepting clock edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [AW-1:0] dest);
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.dest  = dest;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.src_a = ~a;
    bus.src_b = a ^ 18'h15555;
    bus.dest  = ~dest;
  endtask

  // Count falling edges (starting at 1) until the write strobe is seen.
  task automatic waitWb(output int cycles);
    cycles = 1;
    while (bus.wb_en !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int lat;
    int wbSeen;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.dest  = '0;

    repeat (2) @(negedge clk);
    checkOutput("resetBusy",  bus.busy,    0);
    checkOutput("resetWbEn",  bus.wb_en,   0);
    checkOutput("resetWbData", bus.wb_data, 0);
    #2 reset = 1'b0;
    @(negedge clk);

    // MUL 300*500
    applyStimulus(2'b00, 18'd300, 18'd500, 4'd5);
    waitWb(lat);
    checkOutput("mulLatency", lat, 19);
    checkOutput("mulAddr",    bus.wb_addr, 5);
    checkOutput("mulData",    bus.wb_data, 18'h249F0);
    checkOutput("mulDone",    bus.done, 1);
    @(negedge clk);
    checkOutput("mulBusyDrop", bus.busy, 0);
    checkOutput("mulHold",     bus.wb_data, 18'h249F0);

    // MULH / MUL of all-ones operands
    applyStimulus(2'b01, 18'h3FFFF, 18'h3FFFF, 4'd1);
    waitWb(lat);
    checkOutput("mulhData", bus.wb_data, 18'h3FFFE);
    @(negedge clk);
    applyStimulus(2'b00, 18'h3FFFF, 18'h3FFFF, 4'd2);
    waitWb(lat);
    checkOutput("mulLowData", bus.wb_data, 18'h00001);
    @(negedge clk);

    // DIVU then REMU back-to-back with start held high
    bus.op = 2'b10; bus.src_a = 18'd1000; bus.src_b = 18'd7; bus.dest = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    waitWb(lat);
    checkOutput("divLatency", lat, 19);
    checkOutput("divData",    bus.wb_data, 142);
    checkOutput("divAddr",    bus.wb_addr, 3);
    bus.op = 2'b11; bus.dest = 4'd4;
    @(negedge clk);
    checkOutput("b2bIdleGap", bus.busy, 0);
    @(negedge clk);
    checkOutput("b2bAccepted", bus.busy, 1);
    bus.start = 1'b0;
    waitWb(lat);
    checkOutput("remLatency", lat, 19);
    checkOutput("remData",    bus.wb_data, 6);
    checkOutput("remAddr",    bus.wb_addr, 4);
    @(negedge clk);

    // Divide by zero
    applyStimulus(2'b10, 18'd1234, 18'd0, 4'd6);
    waitWb(lat);
    checkOutput("div0Latency", lat, 19);
    checkOutput("div0Data",    bus.wb_data, 18'h3FFFF);
    @(negedge clk);
    applyStimulus(2'b11, 18'd1234, 18'd0, 4'd7);
    waitWb(lat);
    checkOutput("rem0Data", bus.wb_data, 1234);
    @(negedge clk);

    // Abort while count is 9
    applyStimulus(2'b00, 18'd77, 18'd88, 4'd8);
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abortBusy", bus.busy, 0);
    wbSeen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.wb_en === 1'b1 || bus.done === 1'b1) wbSeen++;
    end
    checkOutput("abortNoWrite", wbSeen, 0);
    applyStimulus(2'b00, 18'd3, 18'd4, 4'd9);
    waitWb(lat);
    checkOutput("postAbortData", bus.wb_data, 12);
    checkOutput("postAbortAddr", bus.wb_addr, 9);
    @(negedge clk);

    // Abort in IDLE suppresses a coincident start
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("abortIdle", bus.busy, 0);
    repeat (2) @(negedge clk);

    // Abort in the write cycle: the write is still seen
    applyStimulus(2'b00, 18'd10, 18'd20, 4'd10);
    waitWb(lat);
    bus.abort = 1'b1;
    checkOutput("abortWbData", bus.wb_data, 200);
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abortWbIdle", bus.busy, 0);
    checkOutput("abortWbHold", bus.wb_data, 200);
    @(negedge clk);

    // Asynchronous reset mid-RUN
    applyStimulus(2'b00, 18'd1000, 18'd1000, 4'd11);
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstBusy",   bus.busy,    0);
    checkOutput("rstWbEn",   bus.wb_en,   0);
    checkOutput("rstDone",   bus.done,    0);
    checkOutput("rstWbData", bus.wb_data, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    wbSeen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.wb_en === 1'b1) wbSeen++;
    end
    checkOutput("rstNoWrite",  wbSeen, 0);
    checkOutput("rstDataZero", bus.wb_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
